uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single `uart_tx` byte transmitter between NREQ message sources, e.g. keyboard echo, game-status text and debug dumps.
- Each source presents a short byte string and its length.
- The arbiter grants sources round-robin, latches the string, and sequences it byte-by-byte through the transmitter's `start`/`ready` handshake.
- Sits between the requesters and `uart_tx`, replacing the direct `uart_buf_con` → `uart_tx` hookup.

Parameters:
- NREQ, 3, number of requesters (2..8).
- MAXB, 4, maximum bytes per message.
- LENW, 3, width of each length field; must satisfy 2^LENW > MAXB.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level; held until that requester's ack.
- req_data  input  NREQ*8*MAXB  requester i occupies slice [i*8*MAXB +: 8*MAXB]; the most significant byte is sent first.
- req_len  input  NREQ*LENW  requester i occupies slice [i*LENW +: LENW]; number of bytes to send.
- ack  output  NREQ  one-cycle pulse when requester i's message has been latched.
- done  output  NREQ  one-cycle pulse when requester i's last byte has completed.
- busy  output  1  high in every state except IDLE.
- tstart  output  1  one-cycle start pulse to `uart_tx`.
- tbus  output  8  byte to `uart_tx`.
- tready  input  1  `uart_tx` ready; high when idle, low while shifting.

Behaviour:
- Reset is asynchronous and active-high. All of the following are 0: ack, done, busy, tstart, tbus, the round-robin pointer and the byte counter. State = IDLE.
- Reset mid-message discards the message with no done pulse. A byte already in `uart_tx` completes on its own. After reset, SEND still waits for tready=1 before the next tstart.
- Arbitration:
  - Search starts at index ptr and wraps modulo NREQ.
  - The first asserted req wins.
  - After a grant, ptr <= winner+1, wrapping to 0 after NREQ-1.
  - Requests are sampled only in IDLE; a request arriving mid-message waits.
- IDLE: if any req is high, latch the winner's data, len and index; pulse ack[winner] on the same edge; go to LOAD.
- LOAD:
  - Clamp len to MAXB.
  - len==0: go to FIN, no bytes sent.
  - Otherwise count <= len, byte index <= 0, go to SEND.
- SEND:
  - When tready==1, drive tbus = latched byte[index] and pulse tstart for exactly one cycle; go to WAIT_LO.
  - While tready==0, stay in SEND; tstart stays 0.
- WAIT_LO: stay until tready==0, then go to WAIT_HI. This guards against the transmitter's one-cycle ready lag.
- WAIT_HI:
  - Stay until tready==1.
  - Then count--, index++.
  - count reaches 0: go to FIN (or CR when CRLF_EN is defined).
  - Otherwise go to SEND.
- FIN: pulse done[owner] for one cycle, go to IDLE.
- tbus holds its value from the tstart cycle until the next byte is loaded; it is never changed while tready==0.
- Minimum gap between a requester's ack and the next grant to any requester: message length × byte time + 3 cycles.
- Only one ack bit and one done bit may be high in any cycle.
- A requester that drops req before being granted is skipped, with no error.

Optional Feature:
- Macro: UART_ARB_CRLF_EN.
- Defined:
  - After the last data byte, WAIT_HI goes to CR, which sends 0x0D and then 0x0A, each through the same SEND/WAIT_LO/WAIT_HI handshake.
  - Then go to FIN.
  - A len==0 message sends only CR LF.
- Undefined: no CR/LF states exist; WAIT_HI goes directly to FIN.

Test Plan:
- Single message: req[0]=1, data0=0x4142_0000, len0=2, tready modelled with a 10-cycle busy period → ack[0] the cycle after req; tstart with tbus=0x41, then 0x42; done[0] once; busy low afterwards.
- Fairness: req[0] and req[1] both held with len=1 (data 0xAA…, 0xBB…) → byte order 0xAA then 0xBB. Re-assert both with req[2] too → order continues 2, 0, 1 from ptr=2.
- Length edges:
  - len=0 → ack and done pulses only, no tstart.
  - len=7 with MAXB=4 → exactly 4 bytes sent.
- Backpressure: tready held low for 50 cycles while in SEND → no tstart. When tready rises, tstart pulses once on the next edge.
- Reset mid-message: assert rst during the second byte of a 4-byte message → all outputs 0 immediately, no done. A new request afterwards is served starting from requester 0.
- With UART_ARB_CRLF_EN: len=1, data 0x5A… → bytes 0x5A, 0x0D, 0x0A, then done.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter among NREQ message sources.
// Optional: define UART_ARB_CRLF_EN to append CR LF (0x0D 0x0A) after every message.
module uart_tx_arbiter #(
  parameter int NREQ = 3,
  parameter int MAXB = 4,
  parameter int LENW = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*8*MAXB-1:0] req_data,
  input  logic [NREQ*LENW-1:0]   req_len,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        done,
  output logic                   busy,
  output logic                   tstart,
  output logic [7:0]             tbus,
  input  logic                   tready
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW   = 8 * MAXB;

`ifdef UART_ARB_CRLF_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_SEND = 3'd2, S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4, S_FIN = 3'd5, S_CR = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_SEND = 3'd2, S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4, S_FIN = 3'd5
  } state_t;
`endif

  state_t            r_state;
  logic [PTRW-1:0]   r_ptr;
  logic [PTRW-1:0]   r_owner;
  logic [DW-1:0]     r_data;
  logic [LENW-1:0]   r_len;
  logic [LENW-1:0]   r_count;
  logic [LENW-1:0]   r_idx;
  logic [NREQ-1:0]   r_ack;
  logic [NREQ-1:0]   r_done;
  logic              r_busy;
  logic              r_tstart;
  logic [7:0]        r_tbus;
`ifdef UART_ARB_CRLF_EN
  logic [1:0]        r_tail;
`endif

  logic [PTRW-1:0]   w_win;
  logic              w_any;
  logic [DW-1:0]     w_sel_data;
  logic [LENW-1:0]   w_sel_len;
  logic [LENW-1:0]   w_clamp;
  logic [7:0]        w_byte;
  logic [7:0]        w_tx_byte;

  function automatic logic [PTRW-1:0] wrap_add(input logic [PTRW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    s = (s >= NREQ) ? s - NREQ : s;
    return PTRW'(s);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PTRW-1:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Winner search: walk offsets from far to near so the request closest to r_ptr wins.
  always_comb begin
    w_win = r_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_win = req[wrap_add(r_ptr, k)] ? wrap_add(r_ptr, k) : w_win;
    end
    w_any = |req;
  end

  // Mux the winning requester's string and length.
  always_comb begin
    w_sel_data = '0;
    w_sel_len  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sel_data = (w_win == PTRW'(k)) ? req_data[k*DW +: DW] : w_sel_data;
      w_sel_len  = (w_win == PTRW'(k)) ? req_len[k*LENW +: LENW] : w_sel_len;
    end
  end

  // Byte select, most significant byte first, plus length clamp.
  always_comb begin
    w_byte = 8'h00;
    for (int k = 0; k < MAXB; k++) begin
      w_byte = (r_idx == LENW'(k)) ? r_data[DW-1-8*k -: 8] : w_byte;
    end
    w_clamp = (r_len > LENW'(MAXB)) ? LENW'(MAXB) : r_len;
`ifdef UART_ARB_CRLF_EN
    w_tx_byte = (r_tail == 2'd1) ? 8'h0D : ((r_tail == 2'd2) ? 8'h0A : w_byte);
`else
    w_tx_byte = w_byte;
`endif
  end

  // Main sequencer; every output is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_data   <= '0;
      r_len    <= '0;
      r_count  <= '0;
      r_idx    <= '0;
      r_ack    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_tstart <= 1'b0;
      r_tbus   <= 8'h00;
`ifdef UART_ARB_CRLF_EN
      r_tail   <= 2'd0;
`endif
    end else begin
      r_ack    <= '0;
      r_done   <= '0;
      r_tstart <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_data  <= w_sel_data;
            r_len   <= w_sel_len;
            r_owner <= w_win;
            r_ack   <= onehot(w_win);
            r_ptr   <= wrap_add(w_win, 1);
            r_busy  <= 1'b1;
`ifdef UART_ARB_CRLF_EN
            r_tail  <= 2'd0;
`endif
            r_state <= S_LOAD;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_LOAD: begin
          r_idx <= '0;
          if (w_clamp == LENW'(0)) begin
`ifdef UART_ARB_CRLF_EN
            r_state <= S_CR;
`else
            r_state <= S_FIN;
`endif
          end else begin
            r_count <= w_clamp;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (tready) begin
            r_tbus   <= w_tx_byte;
            r_tstart <= 1'b1;
            r_state  <= S_WAIT_LO;
          end
        end
        // uart_tx drops ready one cycle after start; wait for that before looking for idle.
        S_WAIT_LO: begin
          if (!tready) begin
            r_state <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (tready) begin
`ifdef UART_ARB_CRLF_EN
            if (r_tail == 2'd0) begin
              r_count <= r_count - LENW'(1);
              r_idx   <= r_idx + LENW'(1);
              r_state <= (r_count == LENW'(1)) ? S_CR : S_SEND;
            end else if (r_tail == 2'd1) begin
              r_tail  <= 2'd2;
              r_state <= S_SEND;
            end else begin
              r_state <= S_FIN;
            end
`else
            r_count <= r_count - LENW'(1);
            r_idx   <= r_idx + LENW'(1);
            r_state <= (r_count == LENW'(1)) ? S_FIN : S_SEND;
`endif
          end
        end
`ifdef UART_ARB_CRLF_EN
        S_CR: begin
          r_tail  <= 2'd1;
          r_state <= S_SEND;
        end
`endif
        S_FIN: begin
          r_done  <= onehot(r_owner);
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack    = r_ack;
  assign done   = r_done;
  assign busy   = r_busy;
  assign tstart = r_tstart;
  assign tbus   = r_tbus;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: uart_tx behavioural model plus a queue-based message scoreboard.
module tb_uart_tx_arbiter;

  localparam int NREQ = 3;
  localparam int MAXB = 4;
  localparam int LENW = 3;
  localparam int DW   = 8 * MAXB;
  localparam int BT   = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ*LENW-1:0] req_len = '0;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic                 tstart;
  logic [7:0]           tbus;
  logic                 tready;

  logic                 m_ready = 1'b1;
  int                   m_cnt = 0;
  logic                 hold = 1'b0;

  int total = 0;
  int bad = 0;
  int model_ptr = 0;
  int proto_err = 0;
  logic [31:0] data_a [NREQ];
  int          len_a  [NREQ];
  logic [7:0]  byte_log [$];
  int          ack_log  [$];
  int          done_log [$];
  logic [7:0]  prev_tbus = 8'h00;

  uart_tx_arbiter #(.NREQ(NREQ), .MAXB(MAXB), .LENW(LENW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_len(req_len),
    .ack(ack), .done(done), .busy(busy), .tstart(tstart), .tbus(tbus), .tready(tready)
  );

  always #5 clk = ~clk;

  assign tready = m_ready & ~hold;

  // uart_tx model: ready falls one cycle after start, stays low BT cycles; unaffected by rst.
  always @(posedge clk) begin
    if (tstart) begin
      m_ready <= 1'b0;
      m_cnt   <= BT;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_ready <= 1'b1;
    end
  end

  // Recorder of observed traffic and protocol rule violations.
  always @(negedge clk) begin
    if (tstart) byte_log.push_back(tbus);
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) ack_log.push_back(i);
      if (done[i]) done_log.push_back(i);
    end
    if ($countones(ack) > 1 || $countones(done) > 1) proto_err++;
    if (!rst && !tready && tbus !== prev_tbus) proto_err++;
    prev_tbus = tbus;
  end

  function automatic int pick(input int ptr, input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_msg(input int i, input logic [31:0] d, input int l);
    data_a[i] = d;
    len_a[i]  = l;
    req_data[i*DW +: DW]     = d;
    req_len[i*LENW +: LENW]  = LENW'(l);
  endtask

  task automatic clear_logs();
    byte_log.delete();
    ack_log.delete();
    done_log.delete();
  endtask

  // Present mask, drop each req on its ack, and score grant order and byte stream.
  task automatic run_batch(input logic [NREQ-1:0] mask, input string tag);
    int exp_order [$];
    logic [7:0] exp_bytes [$];
    logic [NREQ-1:0] rem;
    int w, n, cyc, first_ack;
    rem = mask;
    while (rem != '0) begin
      w = pick(model_ptr, rem);
      exp_order.push_back(w);
      rem[w] = 1'b0;
      model_ptr = (w + 1) % NREQ;
      n = (len_a[w] > MAXB) ? MAXB : len_a[w];
      for (int b = 0; b < n; b++) exp_bytes.push_back(8'(data_a[w] >> (8 * (MAXB - 1 - b))));
`ifdef UART_ARB_CRLF_EN
      exp_bytes.push_back(8'h0D);
      exp_bytes.push_back(8'h0A);
`endif
    end
    clear_logs();
    @(negedge clk);
    req = mask;
    cyc = 0;
    first_ack = -1;
    while ((done_log.size() < exp_order.size() || busy) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (ack != '0 && first_ack < 0) first_ack = cyc;
      for (int i = 0; i < NREQ; i++) if (ack[i]) req[i] = 1'b0;
    end
    req = '0;
    total++;
    if (cyc >= 3000) begin bad++; $display("FAIL %s timeout: cycles=%0d limit=3000", tag, cyc); end
    total++;
    if (first_ack != 1) begin bad++; $display("FAIL %s ack_latency: got=%0d want=1", tag, first_ack); end
    total++;
    if (ack_log.size() != exp_order.size() || done_log.size() != exp_order.size()) begin
      bad++;
      $display("FAIL %s grant_count: acks=%0d dones=%0d want=%0d", tag, ack_log.size(), done_log.size(), exp_order.size());
    end
    for (int i = 0; i < exp_order.size(); i++) begin
      total++;
      if (i >= ack_log.size() || i >= done_log.size() || ack_log[i] != exp_order[i] || done_log[i] != exp_order[i]) begin
        bad++;
        $display("FAIL %s grant[%0d]: ack=%0d done=%0d want=%0d", tag, i,
                 (i < ack_log.size()) ? ack_log[i] : -1, (i < done_log.size()) ? done_log[i] : -1, exp_order[i]);
      end
    end
    total++;
    if (byte_log.size() != exp_bytes.size()) begin
      bad++;
      $display("FAIL %s byte_count: got=%0d want=%0d", tag, byte_log.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_bytes.size(); i++) begin
      total++;
      if (i >= byte_log.size() || byte_log[i] !== exp_bytes[i]) begin
        bad++;
        $display("FAIL %s byte[%0d]: got=%h want=%h", tag, i, (i < byte_log.size()) ? byte_log[i] : 8'hxx, exp_bytes[i]);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (ack !== '0 || done !== '0 || busy !== 1'b0 || tstart !== 1'b0 || tbus !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: ack=%b done=%b busy=%b tstart=%b tbus=%h want all 0", ack, done, busy, tstart, tbus);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_fairness();
    set_msg(0, 32'hAA11_2233, 1);
    set_msg(1, 32'hBB44_5566, 1);
    set_msg(2, 32'hCC77_8899, 1);
    run_batch(3'b011, "fair_a");
    total++;
    if (byte_log.size() != 2 || byte_log[0] !== 8'hAA) begin
      bad++;
      $display("FAIL fair_first_byte: got=%h want=aa", (byte_log.size() > 0) ? byte_log[0] : 8'hxx);
    end
    run_batch(3'b111, "fair_b");
    total++;
    if (ack_log.size() != 3 || ack_log[0] != 2 || ack_log[1] != 0 || ack_log[2] != 1) begin
      bad++;
      $display("FAIL fair_rotation: got size=%0d first=%0d want order 2,0,1", ack_log.size(),
               (ack_log.size() > 0) ? ack_log[0] : -1);
    end
  endtask

  task automatic test_single();
    set_msg(0, 32'h4142_0000, 2);
    run_batch(3'b001, "single");
    total++;
    if (byte_log.size() < 2 || byte_log[0] !== 8'h41 || byte_log[1] !== 8'h42) begin
      bad++;
      $display("FAIL single_bytes: got=%h,%h want=41,42", (byte_log.size() > 0) ? byte_log[0] : 8'hxx,
               (byte_log.size() > 1) ? byte_log[1] : 8'hxx);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got=%b want=0", busy); end
  endtask

  task automatic test_len_edges();
    int crlf;
`ifdef UART_ARB_CRLF_EN
    crlf = 2;
`else
    crlf = 0;
`endif
    set_msg(1, 32'h1234_5678, 0);
    run_batch(3'b010, "len0");
    total++;
    if (byte_log.size() != crlf) begin bad++; $display("FAIL len0_bytes: got=%0d want=%0d", byte_log.size(), crlf); end
    set_msg(2, $urandom, 7);
    run_batch(3'b100, "len7");
    total++;
    if (byte_log.size() != MAXB + crlf) begin
      bad++;
      $display("FAIL len7_clamp: got=%0d want=%0d", byte_log.size(), MAXB + crlf);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [31:0] d;
    d = $urandom;
    set_msg(0, d, 1);
    clear_logs();
    hold = 1'b1;
    @(negedge clk);
    req = 3'b001;
    @(negedge clk);
    req = '0;
    repeat (50) @(negedge clk);
    total++;
    if (byte_log.size() != 0 || tstart !== 1'b0) begin
      bad++;
      $display("FAIL bp_no_start: starts=%0d want=0", byte_log.size());
    end
    hold = 1'b0;
    @(negedge clk);
    total++;
    if (tstart !== 1'b1 || tbus !== d[31:24]) begin
      bad++;
      $display("FAIL bp_release: tstart=%b tbus=%h want 1,%h", tstart, tbus, d[31:24]);
    end
    cyc = 0;
    while (done_log.size() == 0 && cyc < 1000) begin @(negedge clk); cyc++; end
    total++;
    if (done_log.size() != 1 || ack_log.size() != 1 || ack_log[0] != 0) begin
      bad++;
      $display("FAIL bp_complete: dones=%0d acks=%0d want 1,1", done_log.size(), ack_log.size());
    end
    model_ptr = 1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    set_msg(0, $urandom, 4);
    clear_logs();
    @(negedge clk);
    req = 3'b001;
    @(negedge clk);
    req = '0;
    cyc = 0;
    while (byte_log.size() < 2 && cyc < 1000) begin @(negedge clk); cyc++; end
    total++;
    if (byte_log.size() < 2) begin bad++; $display("FAIL rmid_reach_byte2: got=%0d want=2", byte_log.size()); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (ack !== '0 || done !== '0 || busy !== 1'b0 || tstart !== 1'b0 || tbus !== 8'h00) begin
      bad++;
      $display("FAIL rmid_outputs: ack=%b done=%b busy=%b tstart=%b tbus=%h want all 0", ack, done, busy, tstart, tbus);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (done_log.size() != 0) begin bad++; $display("FAIL rmid_no_done: got=%0d want=0", done_log.size()); end
    model_ptr = 0;
    set_msg(0, $urandom, $urandom_range(1, 4));
    set_msg(1, $urandom, $urandom_range(1, 4));
    run_batch(3'b011, "rmid_after");
    total++;
    if (ack_log.size() == 0 || ack_log[0] != 0) begin
      bad++;
      $display("FAIL rmid_first_grant: got=%0d want=0", (ack_log.size() > 0) ? ack_log[0] : -1);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] m;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < NREQ; i++) set_msg(i, $urandom, $urandom_range(0, 7));
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run_batch(m, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_len_edges();
    test_backpressure();
    test_reset_mid();
    test_random();
    total++;
    if (proto_err != 0) begin bad++; $display("FAIL protocol_rules: violations=%0d want=0", proto_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
